// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage for the single-cycle RISC-V core.
// Holds the PC and issues word reads to instruction memory over a req/ready
// plus rvalid handshake. Each fetched word is presented with its opcode until
// it is consumed or a redirect arrives. It flags unsupported opcodes, and a
// misaligned redirect target locks the stage in a fault state until reset.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   imem_req_o/addr_o      read request and word address (always the PC)
//   imem_ready_i           memory accepts the request this cycle
//   imem_rvalid_i/rdata_i  read response
//   instr_valid_o          instr_o/opcode_o/pc_out_o hold a fetched word
//   instr_ack_i            consumer takes the presented instruction
//   redirect_i/pc_i        branch/jump redirect and its target
//   illegal_op_o           presented opcode is not supported by the decoder
//   fetch_fault_o          sticky: misaligned redirect seen
//   fetch_count_o          instructions consumed, wraps mod 2^32
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [6:0]  opcode_o,
  output logic [31:0] pc_out_o,
  input  logic        instr_ack_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        illegal_op_o,
  output logic        fetch_fault_o,
  output logic [31:0] fetch_count_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 7;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;
  logic            discard_q, discard_d;
  logic            fault_q, fault_d;
  logic            misaligned;
  logic            op_supported;

  assign misaligned = redirect_i && (redirect_pc_i[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      fetch_count_q <= '0;
      discard_q     <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      fetch_count_q <= fetch_count_d;
      discard_q     <= discard_d;
      fault_q       <= fault_d;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    fetch_count_d = fetch_count_q;
    discard_d     = discard_q;
    fault_d       = fault_q;
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;

    unique case (state_q)
      S_REQ: begin
        // A redirect this cycle would make the current address stale.
        imem_req_o = !redirect_i;
        if (misaligned) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else if (redirect_i) begin
          pc_d = redirect_pc_i;
        end else if (imem_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (misaligned) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          if (redirect_i) begin
            discard_d = 1'b1;
            pc_d      = redirect_pc_i;
          end
          // The in-flight response belongs to an abandoned PC once redirected.
          if (imem_rvalid_i) begin
            if (discard_q || redirect_i) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else begin
              instr_d = imem_rdata_i;
              state_d = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        instr_valid_o = 1'b1;
        if (misaligned) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else if (redirect_i) begin
          pc_d    = redirect_pc_i;
          state_d = S_REQ;
        end else if (instr_ack_i) begin
          pc_d          = pc_q + XLEN'(4);
          fetch_count_d = fetch_count_q + XLEN'(1);
          state_d       = S_REQ;
        end
      end
      S_FAULT: begin
        // Parked until reset; responses and redirects are ignored.
      end
    endcase

    if (rst_i) imem_req_o = 1'b0;
  end

  // Opcodes the main control decoder handles
  always_comb begin
    case (opcode_o)
      7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b0010011, 7'b1100111, 7'b1101111: op_supported = 1'b1;
      default:                            op_supported = 1'b0;
    endcase
  end

  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign opcode_o      = instr_q[OPW-1:0];
  assign pc_out_o      = pc_q;
  assign illegal_op_o  = instr_valid_o && !op_supported;
  assign fetch_fault_o = fault_q;
  assign fetch_count_o = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus a randomized run scored
// against a transaction-level reference model and a behavioural memory.
`timescale 1ns/1ps
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc_out;
  logic        instr_ack = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        illegal_op;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ready_i(imem_ready),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .instr_valid_o(instr_valid), .instr_o(instr), .opcode_o(opcode), .pc_out_o(pc_out),
    .instr_ack_i(instr_ack), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .illegal_op_o(illegal_op), .fetch_fault_o(fetch_fault), .fetch_count_o(fetch_count)
  );

  // Memory contents: opcode chosen by address, includes one unsupported opcode.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] op;
    case (a[4:2])
      3'd0:    op = 7'b0110011;
      3'd1:    op = 7'b0000011;
      3'd2:    op = 7'b0100011;
      3'd3:    op = 7'b1100011;
      3'd4:    op = 7'b0010011;
      3'd5:    op = 7'b1100111;
      3'd6:    op = 7'b1101111;
      default: op = 7'b0001111;
    endcase
    return {a[26:2] ^ 25'h0A55A5A, op};
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b0010011, 7'b1100111, 7'b1101111};
  endfunction

  // Apply one cycle of inputs at the falling edge; outputs settle 1ns later.
  task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic ack, input logic red, input logic [31:0] rpc);
    @(negedge clk);
    rst = r; imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
    instr_ack = ack; redirect = red; redirect_pc = rpc;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    n_vec++; if (imem_req !== 1'b0) begin n_miss++; $display("FAIL rst_req0: got %b want 0", imem_req); end
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (imem_req !== 1'b0) begin n_miss++; $display("FAIL rst_req1: got %b want 0", imem_req); end
    n_vec++; if (instr_valid !== 1'b0) begin n_miss++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_vec++; if (instr !== 32'h0) begin n_miss++; $display("FAIL rst_instr: got %h want 0", instr); end
    n_vec++; if (fetch_fault !== 1'b0) begin n_miss++; $display("FAIL rst_fault: got %b want 0", fetch_fault); end
    n_vec++; if (fetch_count !== 32'h0) begin n_miss++; $display("FAIL rst_count: got %h want 0", fetch_count); end
    n_vec++; if (imem_addr !== RESET_PC) begin n_miss++; $display("FAIL rst_addr: got %h want %h", imem_addr, RESET_PC); end
  endtask

  task automatic test_sequential();
    logic [31:0] addrs[$];
    logic        rv_next = 1'b0;
    logic [31:0] rd_next = 32'h0;
    logic [31:0] w;
    logic [31:0] ea;
    int          k = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, rv_next, rd_next, 1'b1, 1'b0, 32'h0);
      rv_next = 1'b0;
      if (i == 0) begin
        n_vec++; if (imem_req !== 1'b1) begin n_miss++; $display("FAIL seq_first_req: got %b want 1", imem_req); end
        n_vec++; if (imem_addr !== RESET_PC) begin n_miss++; $display("FAIL seq_first_addr: got %h want %h", imem_addr, RESET_PC); end
      end
      if (imem_req === 1'b1) begin
        addrs.push_back(imem_addr);
        rv_next = 1'b1;
        rd_next = mem_word(imem_addr);
      end
      if (instr_valid === 1'b1) begin
        ea = RESET_PC + 32'(4 * k);
        w  = mem_word(ea);
        n_vec++; if (opcode !== w[6:0]) begin n_miss++; $display("FAIL seq_opcode%0d: got %h want %h", k, opcode, w[6:0]); end
        n_vec++; if (pc_out !== ea) begin n_miss++; $display("FAIL seq_pc_out%0d: got %h want %h", k, pc_out, ea); end
        k++;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_vec++; if (fetch_count !== 32'd4) begin n_miss++; $display("FAIL seq_count: got %0d want 4", fetch_count); end
    n_vec++; if (addrs.size() != 4) begin n_miss++; $display("FAIL seq_nreq: got %0d want 4", addrs.size()); end
    for (int j = 0; j < addrs.size() && j < 4; j++) begin
      ea = RESET_PC + 32'(4 * j);
      n_vec++; if (addrs[j] !== ea) begin n_miss++; $display("FAIL seq_addr%0d: got %h want %h", j, addrs[j], ea); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w0 = mem_word(32'h10);
    logic [31:0] w1 = mem_word(32'h14);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, w0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      n_vec++; if (instr_valid !== 1'b1) begin n_miss++; $display("FAIL bp_valid%0d: got %b want 1", i, instr_valid); end
      n_vec++; if (instr !== w0) begin n_miss++; $display("FAIL bp_instr%0d: got %h want %h", i, instr, w0); end
      n_vec++; if (pc_out !== 32'h10) begin n_miss++; $display("FAIL bp_pc%0d: got %h want 10", i, pc_out); end
      n_vec++; if (imem_req !== 1'b0) begin n_miss++; $display("FAIL bp_noreq%0d: got %b want 0", i, imem_req); end
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      n_vec++; if (imem_req !== 1'b1) begin n_miss++; $display("FAIL bp_req%0d: got %b want 1", i, imem_req); end
      n_vec++; if (imem_addr !== 32'h14) begin n_miss++; $display("FAIL bp_addr%0d: got %h want 14", i, imem_addr); end
      n_vec++; if (fetch_count !== 32'd5) begin n_miss++; $display("FAIL bp_cnt%0d: got %0d want 5", i, fetch_count); end
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      n_vec++; if (instr_valid !== 1'b0) begin n_miss++; $display("FAIL bp_wait_valid%0d: got %b want 0", i, instr_valid); end
      n_vec++; if (imem_req !== 1'b0) begin n_miss++; $display("FAIL bp_wait_req%0d: got %b want 0", i, imem_req); end
    end
    drive(1'b0, 1'b0, 1'b1, w1, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (instr !== w1) begin n_miss++; $display("FAIL bp_instr2: got %h want %h", instr, w1); end
    n_vec++; if (fetch_count !== 32'd5) begin n_miss++; $display("FAIL bp_cnt_hold: got %0d want 5", fetch_count); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_vec++; if (fetch_count !== 32'd6) begin n_miss++; $display("FAIL bp_cnt_final: got %0d want 6", fetch_count); end
    n_vec++; if (imem_addr !== 32'h18) begin n_miss++; $display("FAIL bp_addr_final: got %h want 18", imem_addr); end
  endtask

  task automatic test_redirect_wait();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10);
    n_vec++; if (imem_req !== 1'b0) begin n_miss++; $display("FAIL rw_req_redir: got %b want 0", imem_req); end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_vec++; if (imem_addr !== 32'h10) begin n_miss++; $display("FAIL rw_addr10: got %h want 10", imem_addr); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    drive(1'b0, 1'b0, 1'b1, mem_word(32'h10), 1'b0, 1'b0, 32'h0);
    n_vec++; if (instr_valid !== 1'b0) begin n_miss++; $display("FAIL rw_valid_wait: got %b want 0", instr_valid); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_vec++; if (instr_valid !== 1'b0) begin n_miss++; $display("FAIL rw_dropped: got %b want 0", instr_valid); end
    n_vec++; if (imem_req !== 1'b1) begin n_miss++; $display("FAIL rw_req: got %b want 1", imem_req); end
    n_vec++; if (imem_addr !== 32'h100) begin n_miss++; $display("FAIL rw_addr100: got %h want 100", imem_addr); end
  endtask

  task automatic test_redirect_hold();
    logic [31:0] w = mem_word(32'h100);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, w, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40);
    n_vec++; if (instr !== w) begin n_miss++; $display("FAIL rh_instr: got %h want %h", instr, w); end
    n_vec++; if (pc_out !== 32'h100) begin n_miss++; $display("FAIL rh_pc_out: got %h want 100", pc_out); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_vec++; if (instr_valid !== 1'b0) begin n_miss++; $display("FAIL rh_valid: got %b want 0", instr_valid); end
    n_vec++; if (imem_addr !== 32'h40) begin n_miss++; $display("FAIL rh_addr: got %h want 40", imem_addr); end
    n_vec++; if (fetch_count !== 32'd6) begin n_miss++; $display("FAIL rh_count: got %0d want 6", fetch_count); end
  endtask

  task automatic test_illegal_misalign();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_007F, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_vec++; if (instr_valid !== 1'b1) begin n_miss++; $display("FAIL il_valid: got %b want 1", instr_valid); end
    n_vec++; if (illegal_op !== 1'b1) begin n_miss++; $display("FAIL il_illegal: got %b want 1", illegal_op); end
    n_vec++; if (opcode !== 7'h7F) begin n_miss++; $display("FAIL il_opcode: got %h want 7f", opcode); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h102);
    n_vec++; if (imem_req !== 1'b0) begin n_miss++; $display("FAIL mis_req_redir: got %b want 0", imem_req); end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'(i % 2), $urandom, 1'b1, (i == 3), 32'h200);
      n_vec++; if (fetch_fault !== 1'b1) begin n_miss++; $display("FAIL mis_fault%0d: got %b want 1", i, fetch_fault); end
      n_vec++; if (imem_req !== 1'b0) begin n_miss++; $display("FAIL mis_req%0d: got %b want 0", i, imem_req); end
      n_vec++; if (instr_valid !== 1'b0) begin n_miss++; $display("FAIL mis_valid%0d: got %b want 0", i, instr_valid); end
      n_vec++; if (imem_addr !== 32'h44) begin n_miss++; $display("FAIL mis_addr%0d: got %h want 44", i, imem_addr); end
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_vec++; if (fetch_fault !== 1'b0) begin n_miss++; $display("FAIL mis_rst_fault: got %b want 0", fetch_fault); end
    n_vec++; if (imem_addr !== RESET_PC) begin n_miss++; $display("FAIL mis_rst_addr: got %h want %h", imem_addr, RESET_PC); end
    n_vec++; if (imem_req !== 1'b1) begin n_miss++; $display("FAIL mis_rst_req: got %b want 1", imem_req); end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    drive(1'b0, 1'b0, 1'b1, mem_word(RESET_PC), 1'b0, 1'b0, 32'h0);
    release dut.fetch_count_q;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (fetch_count !== 32'hFFFF_FFFF) begin n_miss++; $display("FAIL wrap_pre: got %h want ffffffff", fetch_count); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_vec++; if (fetch_count !== 32'h0) begin n_miss++; $display("FAIL wrap_zero: got %h want 0", fetch_count); end
    n_vec++; if (imem_addr !== RESET_PC + 32'h4) begin n_miss++; $display("FAIL wrap_addr: got %h want %h", imem_addr, RESET_PC + 32'h4); end
  endtask

  task automatic test_random(input int ncyc);
    logic        m_fault = 1'b0, m_out = 1'b0, m_drop = 1'b0, m_have = 1'b0;
    logic [31:0] m_pc = RESET_PC, m_cnt = 32'h0;
    logic        mem_busy = 1'b0;
    int          mem_lat = 0;
    logic [31:0] mem_addr = 32'h0;
    logic        r, rdy, rv, ack, red, exp_req;
    logic [31:0] rd, rpc, w;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < ncyc; c++) begin
      r   = ($urandom_range(0, 149) == 0);
      rdy = 1'($urandom_range(0, 1));
      ack = 1'($urandom_range(0, 1));
      red = ($urandom_range(0, 9) == 0);
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 249) == 0) begin
        red = 1'b1;
        rpc = rpc | 32'($urandom_range(1, 3));
      end
      if (mem_busy && mem_lat == 0) begin rv = 1'b1; rd = mem_word(mem_addr); end
      else if (mem_busy)            begin rv = 1'b0; rd = $urandom; end
      else                          begin rv = ($urandom_range(0, 3) == 0); rd = $urandom; end
      drive(r, rdy, rv, rd, ack, red, rpc);

      exp_req = !r && !m_fault && !m_out && !m_have && !red;
      n_vec++; if (imem_req !== exp_req) begin n_miss++; $display("FAIL rnd_req c%0d: got %b want %b", c, imem_req, exp_req); end
      n_vec++; if (imem_addr !== m_pc) begin n_miss++; $display("FAIL rnd_addr c%0d: got %h want %h", c, imem_addr, m_pc); end
      n_vec++; if (instr_valid !== m_have) begin n_miss++; $display("FAIL rnd_valid c%0d: got %b want %b", c, instr_valid, m_have); end
      n_vec++; if (fetch_fault !== m_fault) begin n_miss++; $display("FAIL rnd_fault c%0d: got %b want %b", c, fetch_fault, m_fault); end
      n_vec++; if (fetch_count !== m_cnt) begin n_miss++; $display("FAIL rnd_count c%0d: got %h want %h", c, fetch_count, m_cnt); end
      if (m_have) begin
        w = mem_word(m_pc);
        n_vec++; if (instr !== w) begin n_miss++; $display("FAIL rnd_instr c%0d: got %h want %h", c, instr, w); end
        n_vec++; if (pc_out !== m_pc) begin n_miss++; $display("FAIL rnd_pc_out c%0d: got %h want %h", c, pc_out, m_pc); end
        n_vec++; if (illegal_op !== !is_legal(w[6:0])) begin n_miss++; $display("FAIL rnd_illegal c%0d: got %b want %b", c, illegal_op, !is_legal(w[6:0])); end
      end else begin
        n_vec++; if (illegal_op !== 1'b0) begin n_miss++; $display("FAIL rnd_illegal_idle c%0d: got %b want 0", c, illegal_op); end
      end

      // Memory reacts to the handshake the DUT actually performed.
      if (r) mem_busy = 1'b0;
      else if (mem_busy) begin
        if (mem_lat == 0) mem_busy = 1'b0;
        else mem_lat--;
      end
      if (!r && imem_req === 1'b1 && rdy) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_lat  = int'($urandom_range(0, 3));
      end

      // Reference model: idle / outstanding / presenting / faulted.
      if (r) begin
        m_fault = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_have = 1'b0;
        m_pc = RESET_PC; m_cnt = 32'h0;
      end else if (m_fault) begin
      end else if (red && rpc[1:0] != 2'b00) begin
        m_fault = 1'b1; m_out = 1'b0; m_have = 1'b0;
      end else if (m_have) begin
        if (red)      begin m_pc = rpc; m_have = 1'b0; end
        else if (ack) begin m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1; m_have = 1'b0; end
      end else if (m_out) begin
        if (rv) begin
          m_out = 1'b0;
          if (m_drop || red) m_drop = 1'b0;
          else m_have = 1'b1;
        end else if (red) m_drop = 1'b1;
        if (red) m_pc = rpc;
      end else begin
        if (red)      m_pc = rpc;
        else if (rdy) m_out = 1'b1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_illegal_misalign();
    test_wrap();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
